// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame layout: LEN_LO, LEN_HI, 4*N payload bytes (little-endian words), CSUM.
package loader_pkg;

  localparam int CNT_W  = 16;
  localparam int BYTE_W = 8;

  localparam logic [1:0] LAST_LANE = 2'd3;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  // A word index never exceeds MAX_WORDS, so the byte address cannot wrap.
  function automatic logic [31:0] word_byte_addr(input logic [CNT_W-1:0] idx);
    return 32'(idx) << 2;
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Packs accepted payload bytes into 32-bit little-endian words {b3,b2,b1,b0}.
// word_ready_o pulses with the accept of the 4th byte while word_o shows the full word.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_ready_o,
  output logic [31:0]       word_o
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;

  // Bytes enter at the top so the oldest byte lands in lane 0 once four are in.
  always_comb begin
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    if (accept_i) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = {byte_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

  assign word_ready_o = accept_i && (byte_idx_q == LAST_LANE);
  assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory
// and holds the core in reset until a complete, verified image has been written.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [31:0]       imem_waddr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_reset_o,
  output logic              load_done_o,
  output logic              load_error_o
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   word_idx_q, word_idx_d;
  logic [BYTE_W-1:0]  xor_q, xor_d;
  logic               imem_we_q;
  logic [31:0]        imem_waddr_q, imem_wdata_q;
  logic               core_reset_q, load_done_q, load_error_q;

  logic               accept, data_accept, word_ready;
  logic [31:0]        word;
  logic [CNT_W-1:0]   len_full;
  logic               len_bad;

  assign rx_ready_o  = !reset_i && (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM});
  assign accept      = rx_valid_i && rx_ready_o;
  assign data_accept = accept && (state_q == S_DATA);
  assign len_full    = {rx_data_i, n_q[7:0]};
  assign len_bad     = (len_full == '0) || (32'(len_full) > MAX_WORDS_W);

  loader_word_asm u_word_asm (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .accept_i     (data_accept),
    .byte_i       (rx_data_i),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    xor_d      = xor_q;
    unique case (state_q)
      S_LEN0: if (accept) begin
        n_d[7:0] = rx_data_i;
        state_d  = S_LEN1;
      end
      // A bad length is rejected before any payload byte is consumed.
      S_LEN1: if (accept) begin
        n_d     = len_full;
        state_d = len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: if (accept) begin
        xor_d = xor_q ^ rx_data_i;
        if (word_ready) begin
          if (word_idx_q == n_q - CNT_W'(1)) state_d = S_CSUM;
          else word_idx_d = word_idx_q + CNT_W'(1);
        end
      end
      S_CSUM: if (accept) begin
        state_d = (rx_data_i == xor_q) ? S_DONE : S_ERROR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_LEN0;
      n_q          <= '0;
      word_idx_q   <= '0;
      xor_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= 32'd0;
      imem_wdata_q <= 32'd0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      xor_q        <= xor_d;
      imem_we_q    <= word_ready;
      if (word_ready) begin
        imem_waddr_q <= word_byte_addr(word_idx_q);
        imem_wdata_q <= word;
      end
      // Status follows the next state so it is visible the cycle after the CSUM accept.
      core_reset_q <= (state_d != S_DONE);
      load_done_q  <= (state_d == S_DONE);
      load_error_q <= (state_d == S_ERROR);
    end
  end

  assign imem_we_o    = imem_we_q;
  assign imem_waddr_o = imem_waddr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign core_reset_o = core_reset_q;
  assign load_done_o  = load_done_q;
  assign load_error_o = load_error_q;

endmodule
